// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the xor_alu operand sequencer: datapath width and FSM states.
package alu_operand_sequencer_pkg;

    localparam int unsigned ALU_WIDTH = 16;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_GOT_A = 2'd1,
        SEQ_EXEC  = 2'd2,
        SEQ_OUT   = 2'd3
    } seq_state_t;

    // Operand beats are only taken while collecting A or B.
    function automatic logic accepts_input(input seq_state_t s);
        return (s == SEQ_IDLE) || (s == SEQ_GOT_A);
    endfunction

endpackage

// File: rtl/alu_operand_sequencer.sv
// Serial operand front-end for xor_alu: collects A then B over one valid/ready bus,
// holds them on the ALU inputs, captures the result with a zero flag and hands it
// downstream over a second valid/ready handshake, counting completed operations.
module alu_operand_sequencer
    import alu_operand_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_g,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_zero;
    logic [CNT_W-1:0] r_op_count;
    logic             w_in_fire;
    logic             w_out_fire;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // Next-state selection; flush overrides every handshake.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            SEQ_IDLE:  if (w_in_fire)  w_next = SEQ_GOT_A;
            SEQ_GOT_A: if (w_in_fire)  w_next = SEQ_EXEC;
            SEQ_EXEC:                  w_next = SEQ_OUT;
            SEQ_OUT:   if (out_ready)  w_next = SEQ_IDLE;
            default:                   w_next = SEQ_IDLE;
        endcase
        if (flush) begin
            w_next = SEQ_IDLE;
        end
    end

    // State register; handshake/status outputs are registered decodes of the next state,
    // so they track the state exactly while coming straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SEQ_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= accepts_input(w_next);
            r_out_valid <= (w_next == SEQ_OUT);
            r_busy      <= (w_next != SEQ_IDLE);
        end
    end

    // Operand, result and counter registers; flush clears operands/result but not the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_out_data <= '0;
            r_out_zero <= 1'b0;
            r_op_count <= '0;
        end else if (flush) begin
            r_a        <= '0;
            r_b        <= '0;
            r_out_data <= '0;
            r_out_zero <= 1'b0;
        end else begin
            if ((r_state == SEQ_IDLE) && w_in_fire) begin
                r_a <= in_data;
            end
            if ((r_state == SEQ_GOT_A) && w_in_fire) begin
                r_b <= in_data;
            end
            if (r_state == SEQ_EXEC) begin
                r_out_data <= alu_g;
                r_out_zero <= (alu_g == '0);
            end
            if ((r_state == SEQ_OUT) && w_out_fire) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign out_data  = r_out_data;
    assign out_zero  = r_out_zero;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer with an XOR stand-in for xor_alu and a 4-bit counter.
module tb_alu_operand_sequencer;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [W-1:0]  alu_g;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_zero;
    logic          busy;
    logic [CW-1:0] op_count;

    typedef struct {
        logic [W-1:0] d;
        logic         z;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    logic [CW-1:0] m_count = '0;
    int            n_checks = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    assign alu_g = alu_a ^ alu_b;

    alu_operand_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_g(alu_g),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero),
        .busy(busy), .op_count(op_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic beat(input logic [W-1:0] d);
        int unsigned n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("beat_timeout", 32'(in_ready), 32'd1);
        end else begin
            in_valid = 1'b1;
            in_data  = d;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = W'($urandom);
        end
    endtask

    // Issue one A/B pair; the expected result is the XOR of the two operands.
    task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit check_lat);
        exp_t e;
        beat(a);
        beat(b);
        e.d = a ^ b;
        e.z = ((a ^ b) == 0);
        sb_q.push_back(e);
        if (check_lat) begin
            @(negedge clk);
            chk("lat_exec_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
            chk("lat_out_valid", 32'(out_valid), 32'd1);
        end
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Monitor: every downstream transfer is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                chk("out_data", 32'(out_data), 32'(mon_e.d));
                chk("out_zero", 32'(out_zero), 32'(mon_e.z));
                chk("op_count_pre", 32'(op_count), 32'(m_count));
                m_count = m_count + 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #13;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_alu_a",     32'(alu_a),     32'd0);
        chk("rst_alu_b",     32'(alu_b),     32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_zero",  32'(out_zero),  32'd0);
        chk("rst_op_count",  32'(op_count),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic ops, including a zero result
        send_op(16'h0001, 16'h0003, 1'b1);
        wait_idle();
        chk("t1_count", 32'(op_count), 32'd1);
        send_op(16'h0007, 16'h0007, 1'b1);
        send_op(16'h0002, 16'h0006, 1'b1);
        wait_idle();

        // Backpressure: result held, input blocked, stray beats ignored
        out_ready = 1'b0;
        send_op(16'h0004, 16'h0001, 1'b1);
        repeat (5) begin
            chk("bp_valid",    32'(out_valid), 32'd1);
            chk("bp_data",     32'(out_data),  32'h5);
            chk("bp_in_ready", 32'(in_ready),  32'd0);
            chk("bp_alu_a",    32'(alu_a),     32'h4);
            chk("bp_alu_b",    32'(alu_b),     32'h1);
            in_valid = 1'b1;
            in_data  = W'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        chk("bp_count", 32'(op_count), 32'(m_count));

        // Asynchronous reset mid-operation
        beat(16'h1234);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",     32'(busy),     32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_alu_a",    32'(alu_a),    32'd0);
        chk("arst_count",    32'(op_count), 32'd0);
        sb_q.delete();
        m_count = '0;
        @(negedge clk);
        rst_n = 1'b1;
        send_op(16'h00F0, 16'h000F, 1'b1);
        wait_idle();

        // Flush while holding A
        beat(16'hBEEF);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flA_busy",     32'(busy),     32'd0);
        chk("flA_alu_a",    32'(alu_a),    32'd0);
        chk("flA_in_ready", 32'(in_ready), 32'd1);

        // Flush in OUT with out_ready high: result discarded, count untouched
        out_ready = 1'b0;
        send_op(16'h0009, 16'h0030, 1'b1);
        #1;
        flush = 1'b1;
        out_ready = 1'b1;
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flO_valid", 32'(out_valid), 32'd0);
        chk("flO_data",  32'(out_data),  32'd0);
        chk("flO_zero",  32'(out_zero),  32'd0);
        chk("flO_alu_b", 32'(alu_b),     32'd0);
        chk("flO_count", 32'(op_count),  32'(m_count));

        // Back-to-back random ops; the 4-bit counter wraps
        for (int i = 0; i < 20; i++) begin
            send_op(W'($urandom), W'($urandom), 1'b1);
        end
        wait_idle();
        chk("wrap_count", 32'(op_count), 32'(m_count));
        chk("sb_drain",   32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
